regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and register scoreboard for the single-write-port register file. Up to NUM_REQ result producers (ALU, load unit, multi-cycle mul/div) compete for the port through valid/ready handshakes. A round-robin grant drives the port with registered rd_addr/write_data/reg_write_en. Per-register pending counters tell the issue stage which source registers still await a write-back.

## Interface
- NUM_REQ, default 3: number of write-back requesters (2..8).
- XLEN, default 32: data width.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  requester i holds a result.
- req_ready  output  NUM_REQ  one-hot grant; combinational from req_valid and the priority pointer.
- req_rd  input  NUM_REQ*5  destination register of requester i (slice i).
- req_data  input  NUM_REQ*XLEN  result of requester i (slice i).
- rd_addr  output  5  to register file, registered.
- write_data  output  XLEN  to register file, registered.
- reg_write_en  output  1  to register file, registered.
- issue_valid  input  1  issue stage dispatches an instruction writing issue_rd.
- issue_rd  input  5  destination register of the issued instruction.
- issue_ready  output  1  issue may proceed (counter for issue_rd below 3).
- rs1_q, rs2_q  input  5 each  source registers queried by issue.
- rs1_busy, rs2_busy  output  1 each  queried register has a pending write; combinational.

## Operation
- Arbitration: round-robin. ptr (clog2(NUM_REQ) bits) names the highest-priority requester. The first valid requester found scanning ptr, ptr+1, … (mod NUM_REQ) gets req_ready=1; all others get 0. At most one ready bit is high.
- Handshake: transfer completes at the rising edge where req_valid[i] & req_ready[i]. Requester must hold req_rd/req_data stable while valid and not ready. Valid must not drop before the handshake.
- On a handshake from i:
  - rd_addr <= req_rd[i].
  - write_data <= req_data[i].
  - reg_write_en <= (req_rd[i] != 0).
  - ptr <= (i+1) mod NUM_REQ.
- No handshake: reg_write_en <= 0; rd_addr and write_data hold their values; ptr holds.
- x0: a write-back to rd=0 is accepted and consumed, but reg_write_en stays 0. Issue to x0 never touches a counter. rs*_q=0 always reports busy=0.
- Scoreboard: cnt[r] is 2 bits for r=1..31.
  - Increment on issue_valid & issue_ready with issue_rd=r.
  - Decrement at the edge ending a cycle in which reg_write_en=1 and rd_addr=r (write has landed).
  - Increment and decrement on the same r in the same cycle: cnt unchanged.
- issue_ready = (issue_rd==0) | (cnt[issue_rd] != 3), evaluated on the current count. issue_valid while issue_ready=0 is ignored.
- rsN_busy = (rsN_q != 0) & (cnt[rsN_q] != 0).
- Decrement of a zero counter (write-back with no matching issue) saturates at 0. This is a protocol error; the block does not flag it.

## Timing
- Reset values: rd_addr=0, write_data=0, reg_write_en=0, ptr=0, all cnt=0. req_ready=0 and issue_ready=1 while rst_n=0.
- Handshake at edge T: reg_write_en/rd_addr/write_data valid for the cycle T..T+1. The register file commits within that cycle. cnt decrements at edge T+1, so busy drops exactly when the new value is readable.
- Throughput: one write-back per cycle. Back-to-back grants are allowed with no bubble.
- Fairness: with all requesters continuously valid, each is granted once every NUM_REQ cycles.
- Reset asserted mid-operation clears everything immediately, including a pending reg_write_en. That write is lost.

## Test plan
- Reset:
  - Stimulus: rst_n=0 with all requesters valid.
  - Response: req_ready=0, reg_write_en=0, rd_addr=0, write_data=0.
  - After release, the first grant goes to requester 0.
- Single write:
  - Stimulus: req 1 valid, rd=5, data=0xDEADBEEF.
  - Response: ready[1] in the same cycle. Next cycle reg_write_en=1, rd_addr=5, write_data=0xDEADBEEF. The following cycle reg_write_en=0.
- Round-robin:
  - Stimulus: all 3 requesters valid for 6 cycles (rd=1,2,3; data 0x11,0x22,0x33).
  - Response: grant order 0,1,2,0,1,2. rd_addr sequence 1,2,3,1,2,3, each one cycle after its grant.
- x0 write:
  - Stimulus: req 0 valid, rd=0, data=0xFFFFFFFF.
  - Response: ready[0]=1, reg_write_en stays 0, no counter changes.
- Scoreboard:
  - Stimulus: issue rd=7; query rs1_q=7; later req 2 writes rd=7.
  - Response: rs1_busy=1 from the cycle after issue. It stays 1 through the cycle with reg_write_en=1 and drops at the next edge.
- Counter saturation:
  - Stimulus: issue rd=9 three times.
  - Response: issue_ready=0 for rd=9 and a fourth issue is ignored. After one write-back to x9 lands, issue_ready=1. Simultaneous issue and landing write on x9 leaves cnt unchanged.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the single register-file write port,
// plus per-register pending-write counters consulted by the issue stage.
module regfile_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*5-1:0]    req_rd,
   input  logic [NUM_REQ*XLEN-1:0] req_data,
   output logic [4:0]              rd_addr,
   output logic [XLEN-1:0]         write_data,
   output logic                    reg_write_en,
   input  logic                    issue_valid,
   input  logic [4:0]              issue_rd,
   output logic                    issue_ready,
   input  logic [4:0]              rs1_q,
   input  logic [4:0]              rs2_q,
   output logic                    rs1_busy,
   output logic                    rs2_busy
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PW-1:0]     ptr_q, ptr_d;
   logic [4:0]        rd_addr_q, rd_addr_d;
   logic [XLEN-1:0]   write_data_q, write_data_d;
   logic              reg_write_en_q, reg_write_en_d;
   logic [1:0]        cnt_q [32];
   logic [1:0]        cnt_d [32];

   logic [NUM_REQ-1:0] grant;
   logic [PW-1:0]      grant_idx;
   logic               grant_any;
   logic               issue_fire;

   // Handshake: requester i transfers at the rising edge where
   // req_valid[i] & req_ready[i]; it holds rd/data stable until then.
   always_comb begin
      int j;
      j         = 0;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr_q) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!grant_any && req_valid[j]) begin
            grant_any = 1'b1;
            grant_idx = PW'(j);
         end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
   end

   assign req_ready = rst_n ? grant : '0;

   always_comb begin
      ptr_d          = ptr_q;
      rd_addr_d      = rd_addr_q;
      write_data_d   = write_data_q;
      reg_write_en_d = 1'b0;
      if (grant_any) begin
         rd_addr_d      = req_rd[int'(grant_idx)*5 +: 5];
         write_data_d   = req_data[int'(grant_idx)*XLEN +: XLEN];
         reg_write_en_d = (req_rd[int'(grant_idx)*5 +: 5] != 5'd0);
         ptr_d          = (int'(grant_idx) == NUM_REQ-1) ? '0 : grant_idx + 1'b1;
      end
   end

   assign issue_ready = (issue_rd == 5'd0) || (cnt_q[issue_rd] != 2'd3);
   assign issue_fire  = issue_valid && issue_ready && (issue_rd != 5'd0);

   // A write retires its pending count the edge after it is presented, so
   // busy clears exactly when the register file can return the new value.
   always_comb begin
      logic inc, dec;
      inc = 1'b0;
      dec = 1'b0;
      cnt_d[0] = 2'd0;
      for (int r = 1; r < 32; r++) begin
         cnt_d[r] = cnt_q[r];
         inc = issue_fire && (issue_rd == 5'(r));
         dec = reg_write_en_q && (rd_addr_q == 5'(r));
         if (inc && !dec)
            cnt_d[r] = cnt_q[r] + 2'd1;
         else if (dec && !inc && (cnt_q[r] != 2'd0))
            cnt_d[r] = cnt_q[r] - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q          <= '0;
         rd_addr_q      <= '0;
         write_data_q   <= '0;
         reg_write_en_q <= 1'b0;
         for (int r = 0; r < 32; r++) cnt_q[r] <= 2'd0;
      end else begin
         ptr_q          <= ptr_d;
         rd_addr_q      <= rd_addr_d;
         write_data_q   <= write_data_d;
         reg_write_en_q <= reg_write_en_d;
         for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
      end
   end

   assign rd_addr      = rd_addr_q;
   assign write_data   = write_data_q;
   assign reg_write_en = reg_write_en_q;
   assign rs1_busy     = (rs1_q != 5'd0) && (cnt_q[rs1_q] != 2'd0);
   assign rs2_busy     = (rs2_q != 5'd0) && (cnt_q[rs2_q] != 2'd0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, write-back
// timing, x0 handling and the pending-write scoreboard.
module tb_regfile_wb_arbiter;

   localparam int NR = 3;
   localparam int XL = 32;

   logic            clk;
   logic            rst_n;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [NR*5-1:0] req_rd;
   logic [NR*XL-1:0] req_data;
   logic [4:0]      rd_addr;
   logic [XL-1:0]   write_data;
   logic            reg_write_en;
   logic            issue_valid;
   logic [4:0]      issue_rd;
   logic            issue_ready;
   logic [4:0]      rs1_q, rs2_q;
   logic            rs1_busy, rs2_busy;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_wb_arbiter #(.NUM_REQ(NR), .XLEN(XL)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_rd(req_rd), .req_data(req_data),
      .rd_addr(rd_addr), .write_data(write_data), .reg_write_en(reg_write_en),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
      .rs1_q(rs1_q), .rs2_q(rs2_q), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_req(input int idx, input logic [4:0] rd, input logic [XL-1:0] data);
      req_valid[idx]          = 1'b1;
      req_rd[idx*5 +: 5]      = rd;
      req_data[idx*XL +: XL]  = data;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = '1;
      req_rd = {5'd3, 5'd2, 5'd1};
      req_data = {32'h33, 32'h22, 32'h11};
      issue_valid = 1'b0; issue_rd = '0; rs1_q = '0; rs2_q = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b exp 000", req_ready); end
      n_checks++; if (reg_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b exp 0", reg_write_en); end
      n_checks++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d exp 0", rd_addr); end
      n_checks++; if (write_data !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h exp 0", write_data); end
      n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready: got %b exp 1", issue_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL reset_first_grant: got %b exp 001", req_ready); end
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_g;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) begin @(negedge clk); #1; end
         exp_g = 3'b001 << (c % 3);
         n_checks++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL rr_grant%0d: got %b exp %b", c, req_ready, exp_g); end
         @(posedge clk); #1;
         n_checks++; if (rd_addr !== 5'((c % 3) + 1)) begin n_fail++; $display("FAIL rr_rd%0d: got %0d exp %0d", c, rd_addr, (c % 3) + 1); end
         n_checks++; if (write_data !== 32'(32'h11 * ((c % 3) + 1))) begin n_fail++; $display("FAIL rr_data%0d: got %h exp %h", c, write_data, 32'h11 * ((c % 3) + 1)); end
         n_checks++; if (reg_write_en !== 1'b1) begin n_fail++; $display("FAIL rr_we%0d: got %b exp 1", c, reg_write_en); end
      end
      req_valid = '0;
      @(posedge clk); #1;
      n_checks++; if (reg_write_en !== 1'b0) begin n_fail++; $display("FAIL rr_idle_we: got %b exp 0", reg_write_en); end
   endtask

   task automatic test_single_write();
      @(negedge clk);
      set_req(1, 5'd5, 32'hDEADBEEF);
      #1;
      n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL single_ready: got %b exp 010", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      n_checks++; if (reg_write_en !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b exp 1", reg_write_en); end
      n_checks++; if (rd_addr !== 5'd5) begin n_fail++; $display("FAIL single_rd: got %0d exp 5", rd_addr); end
      n_checks++; if (write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h exp deadbeef", write_data); end
      @(posedge clk); #1;
      n_checks++; if (reg_write_en !== 1'b0) begin n_fail++; $display("FAIL single_we_off: got %b exp 0", reg_write_en); end
      n_checks++; if (write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_hold: got %h exp deadbeef", write_data); end
   endtask

   task automatic test_x0_write();
      @(negedge clk);
      set_req(0, 5'd0, 32'hFFFFFFFF);
      rs1_q = 5'd0;
      #1;
      n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL x0_ready: got %b exp 001", req_ready); end
      n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL x0_busy: got %b exp 0", rs1_busy); end
      @(posedge clk); #1;
      req_valid = '0;
      n_checks++; if (reg_write_en !== 1'b0) begin n_fail++; $display("FAIL x0_we: got %b exp 0", reg_write_en); end
      n_checks++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL x0_rd: got %0d exp 0", rd_addr); end
      n_checks++; if (write_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL x0_data: got %h exp ffffffff", write_data); end
   endtask

   task automatic test_scoreboard();
      @(negedge clk);
      issue_valid = 1'b1; issue_rd = 5'd7; rs1_q = 5'd7; rs2_q = 5'd7;
      #1;
      n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sb_issue_ready: got %b exp 1", issue_ready); end
      n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL sb_busy_before: got %b exp 0", rs1_busy); end
      @(posedge clk); #1;
      issue_valid = 1'b0;
      n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy_after_issue: got %b exp 1", rs1_busy); end
      n_checks++; if (rs2_busy !== 1'b1) begin n_fail++; $display("FAIL sb_rs2_busy: got %b exp 1", rs2_busy); end
      @(negedge clk);
      set_req(2, 5'd7, 32'h77);
      #1;
      n_checks++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL sb_ready: got %b exp 100", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      n_checks++; if (reg_write_en !== 1'b1 || rd_addr !== 5'd7) begin n_fail++; $display("FAIL sb_write: got we=%b rd=%0d exp we=1 rd=7", reg_write_en, rd_addr); end
      n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy_during_write: got %b exp 1", rs1_busy); end
      @(posedge clk); #1;
      n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL sb_busy_cleared: got %b exp 0", rs1_busy); end
   endtask

   task automatic test_saturation();
      @(negedge clk);
      issue_valid = 1'b1; issue_rd = 5'd9; rs1_q = 5'd9;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL sat_full: got %b exp 0", issue_ready); end
      @(posedge clk); #1;
      issue_valid = 1'b0;
      n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL sat_fourth_ignored: got %b exp 0", issue_ready); end
      @(negedge clk);
      set_req(0, 5'd9, 32'h99);
      @(posedge clk); #1;
      req_valid = '0;
      n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL sat_before_land: got %b exp 0", issue_ready); end
      @(posedge clk); #1;
      n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_after_land: got %b exp 1", issue_ready); end
      // count is 2; land another write on x9 while issuing x9
      @(negedge clk);
      set_req(0, 5'd9, 32'h9A);
      @(posedge clk); #1;
      req_valid = '0;
      issue_valid = 1'b1;
      @(posedge clk); #1;
      issue_valid = 1'b0;
      n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_simul_unchanged: got %b exp 1", issue_ready); end
      issue_valid = 1'b1;
      @(posedge clk); #1;
      issue_valid = 1'b0;
      n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL sat_refill: got %b exp 0", issue_ready); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      set_req(1, 5'd4, 32'h44);
      @(posedge clk); #1;
      n_checks++; if (reg_write_en !== 1'b1) begin n_fail++; $display("FAIL mid_we_pre: got %b exp 1", reg_write_en); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (reg_write_en !== 1'b0 || rd_addr !== 5'd0 || write_data !== 32'd0) begin n_fail++; $display("FAIL mid_regs: got we=%b rd=%0d data=%h exp 0", reg_write_en, rd_addr, write_data); end
      n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL mid_ready: got %b exp 000", req_ready); end
      n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL mid_cnt_clear: got %b exp 1", issue_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = '1;
      #1;
      n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL mid_ptr_clear: got %b exp 001", req_ready); end
      req_valid = '0;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single_write();
      test_x0_write();
      test_scoreboard();
      test_saturation();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
